// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the load/store port,
// tracking outstanding reads so each in-order response is routed back to its originator.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int ST_W  = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} occ_e;

  logic [PTR_W:0]   cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [MAX_OUT-1:0] tag_q;
  logic [ST_W-1:0]  starve_cnt;
  occ_e             occ;
  logic             open, sel_d, sel_if, push, pop, head;

  always_comb begin
    occ = IDLE;
    if (cnt == (PTR_W+1)'(MAX_OUT)) occ = FULL;
    else if (cnt != '0)             occ = BUSY;
  end

  // Fetch only overrides a pending data request once it has been denied STARVE_LIM cycles in a row.
  assign open   = !rst && (occ != FULL);
  assign sel_d  = open && d_req && !(if_req && (starve_cnt == ST_W'(STARVE_LIM)));
  assign sel_if = open && if_req && !sel_d;

  assign mem_req   = sel_d | sel_if;
  assign mem_we    = sel_d & d_we;
  assign mem_addr  = sel_d ? d_addr : (sel_if ? if_addr : '0);
  assign mem_wdata = sel_d ? d_wdata : '0;
  assign mem_be    = sel_d ? d_be : (sel_if ? 4'hF : 4'h0);

  assign if_gnt = sel_if & mem_gnt;
  assign d_gnt  = sel_d & mem_gnt;

  assign push = if_gnt | (d_gnt & ~d_we);
  assign pop  = !rst && mem_rvalid && (occ != IDLE);
  assign head = tag_q[rd_ptr];

  assign if_rvalid = pop & ~head;
  assign d_rvalid  = pop & head;
  assign if_rdata  = rst ? '0 : mem_rdata;
  assign d_rdata   = rst ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
      if (if_req && !if_gnt)
        starve_cnt <= (starve_cnt == ST_W'(STARVE_LIM)) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
    end
  end

  // NOTE: tag storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr] <= d_gnt;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) mem_rvalid |-> (cnt != '0))
    else $error("mem_rvalid arrived with no outstanding read");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a one-cycle memory responder, a response scoreboard
// filled at grant time and a monitor that pops it whenever a response is routed out.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] pend[$];
  bit          resp_en;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .MAX_OUT(4), .STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are defined as 0xA5A5_0000 | address; reads return one cycle after grant.
  initial begin
    logic        have;
    logic [31:0] nxt;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_gnt && !mem_we) pend.push_back(mem_addr);
      have = resp_en && (pend.size() > 0);
      nxt  = have ? (32'hA5A5_0000 | pend.pop_front()) : 32'h0;
      @(posedge clk); #1;
      mem_rvalid = have;
      mem_rdata  = nxt;
    end
  end

  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid || d_rvalid) begin
        check("rvalid_onehot", {31'b0, if_rvalid & d_rvalid}, 32'h0);
        if (sb.size() == 0) begin
          check("unexpected_rsp", {31'b0, d_rvalid}, {31'b0, ~d_rvalid});
        end else begin
          e = sb.pop_front();
          check("rsp_tag", {31'b0, d_rvalid}, {31'b0, e.is_d});
          check("rsp_data", d_rvalid ? d_rdata : if_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One request from a single requester, expected to be granted in the cycle it is presented.
  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr, input string name);
    if_req  = !is_d;
    d_req   = is_d;
    d_we    = we;
    if_addr = addr;
    d_addr  = addr;
    d_wdata = 32'hC0DE_0000 | addr;
    d_be    = 4'b1010;
    @(negedge clk);
    check({name, "_gnt"}, {31'b0, is_d ? d_gnt : if_gnt}, 32'h1);
    check({name, "_addr"}, mem_addr, addr);
    check({name, "_we"}, {31'b0, mem_we}, {31'b0, we});
    if (we) begin
      check({name, "_wdata"}, mem_wdata, 32'hC0DE_0000 | addr);
      check({name, "_be"}, {28'b0, mem_be}, 32'hA);
    end else begin
      sb.push_back('{is_d, 32'hA5A5_0000 | addr});
    end
    next_cycle();
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    check({name, "_drained"}, sb.size(), 32'h0);
    next_cycle();
  endtask

  task automatic expect_quiet(input string name);
    check({name, "_mem_req"}, {31'b0, mem_req}, 32'h0);
    check({name, "_if_gnt"}, {31'b0, if_gnt}, 32'h0);
    check({name, "_d_gnt"}, {31'b0, d_gnt}, 32'h0);
    check({name, "_rvalid"}, {30'b0, if_rvalid, d_rvalid}, 32'h0);
    check({name, "_mem_addr"}, mem_addr, 32'h0);
  endtask

  initial begin
    logic [4:0] win_pat;
    rst = 1'b1; resp_en = 1'b1; mem_gnt = 1'b1;
    if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h100; d_wdata = '0; d_be = '0;

    // Reset state with both requesters asserting.
    repeat (2) @(negedge clk);
    expect_quiet("reset");
    check("reset_if_rdata", if_rdata, 32'h0);
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    next_cycle();

    // Fetch-only stream.
    issue(0, 0, 32'h0, "fetch0");
    issue(0, 0, 32'h4, "fetch1");
    issue(0, 0, 32'h8, "fetch2");
    drain("fetch");

    // Both requesting: data stores win three times, then the starved fetch wins once.
    win_pat = 5'b01000;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h200; d_wdata = 32'hDEAD_0001; d_be = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      if_addr = (i <= 3) ? 32'h20 : 32'h24;
      @(negedge clk);
      check($sformatf("starve%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, win_pat[i]});
      check($sformatf("starve%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, ~win_pat[i]});
      check($sformatf("starve%0d_addr", i), mem_addr, win_pat[i] ? 32'h20 : 32'h200);
      check($sformatf("starve%0d_we", i), {31'b0, mem_we}, {31'b0, ~win_pat[i]});
      if (win_pat[i]) sb.push_back('{1'b0, 32'hA5A5_0020});
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    drain("starve");

    // Interleave fetch, load, store.
    issue(0, 0, 32'h10, "ilv_fetch");
    issue(1, 0, 32'h100, "ilv_load");
    issue(1, 1, 32'h104, "ilv_store");
    drain("ilv");

    // Fill the owner queue with the memory stalled.
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) issue(0, 0, 32'h40 + 32'(4 * i), $sformatf("full_fill%0d", i));
    if_req = 1'b1; if_addr = 32'h50;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_if_gnt", {31'b0, if_gnt}, 32'h0);
      check("full_mem_req", {31'b0, mem_req}, 32'h0);
      next_cycle();
    end
    resp_en = 1'b1;
    @(negedge clk);
    check("full_wait_mem_req", {31'b0, mem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("full_pop_if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("full_pop_if_gnt", {31'b0, if_gnt}, 32'h0);
    check("full_pop_mem_req", {31'b0, mem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("full_after_if_gnt", {31'b0, if_gnt}, 32'h1);
    check("full_after_addr", mem_addr, 32'h50);
    sb.push_back('{1'b0, 32'hA5A5_0050});
    next_cycle();
    if_req = 1'b0;
    drain("full");

    // Steady push+pop at two outstanding, wrapping the pointers several times.
    resp_en = 1'b0;
    issue(0, 0, 32'h80, "wrap_a");
    resp_en = 1'b1;
    issue(1, 0, 32'h300, "wrap_b");
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) issue(1, 0, 32'h304 + 32'(4 * i), $sformatf("wrap_d%0d", i));
      else            issue(0, 0, 32'h84 + 32'(4 * i), $sformatf("wrap_if%0d", i));
    end
    drain("wrap");

    // Reset with two reads outstanding; their late responses must be dropped.
    resp_en = 1'b0;
    issue(0, 0, 32'h60, "rst_a");
    issue(0, 0, 32'h64, "rst_b");
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h68; d_req = 1'b1; d_we = 1'b0;
    sb.delete();
    @(negedge clk);
    expect_quiet("midrst");
    resp_en = 1'b1;
    next_cycle();
    @(negedge clk);
    expect_quiet("midrst_rsp");
    check("midrst_if_rdata", if_rdata, 32'h0);
    repeat (3) next_cycle();
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    next_cycle();
    issue(0, 0, 32'h70, "post_rst");
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
